memory_stage: RTL and testbench
===============================

MEMORY_STAGE -- requirements
Module: memory_stage

Interface
REQ-001 Clocking SHALL be: one clock; reset is synchronous and active-high.
REQ-002 i_clk  in  1  rising-edge clock.
REQ-003 i_rst  in  1  synchronous active-high reset.
REQ-004 i_rd_wren_m, i_mem_wren_m  in  1 each  register-write enable; store enable.
REQ-005 i_wb_sel_m  in  2  writeback source: 00 ALU, 01 load, 10 pc+4, 11 ALU.
REQ-006 i_funct3_m  in  3  access size/sign.
REQ-007 i_rd_m  in  5  destination register.
REQ-008 i_pc_four_m, i_st_data_m, i_alu_data_m  in  32 each  pc+4; store data; ALU result/address.
REQ-009 o_dmem_req, o_dmem_we  out  1 each  bus request; write qualifier.
REQ-010 o_dmem_addr, o_dmem_wdata  out  32 each  word address {alu[31:2],2'b00}; lane-replicated store data.
REQ-011 o_dmem_be  out  4  byte enables.
REQ-012 i_dmem_ack  in  1; i_dmem_rdata  in  32  completion; read word.
REQ-013 o_stall_m  out  1  holds upstream stages and the EX/MEM register.
REQ-014 o_rd_wren_w, o_rd_w (5), o_wb_data_w (32), o_misalign_w, o_bus_err_w  out  MEM/WB register outputs.

Function
REQ-015 Access = i_mem_wren_m or (i_wb_sel_m==01); load when wb_sel==01 and mem_wren==0.
REQ-016 Misaligned: halfword (funct3[1:0]==01) with addr[0]=1, or word (funct3[1:0]==10) with addr[1:0]!=0.
REQ-017 Misaligned access SHALL issue no request and no stall; next edge registers o_rd_wren_w=0, o_misalign_w=1.
REQ-018 FSM states IDLE, BUSY; 4-bit wait counter.
REQ-019 IDLE, aligned access: o_dmem_req=1 same cycle; ack same cycle -> complete, no stall, stay IDLE.
REQ-020 IDLE, aligned access, no ack: o_stall_m=1; next edge -> BUSY, counter=1.
REQ-021 BUSY: o_dmem_req=1, outputs stable, o_stall_m=1 while no ack, counter increments each cycle.
REQ-022 BUSY with ack: o_stall_m=0, complete, next edge -> IDLE, counter=0.
REQ-023 BUSY with counter==15 and no ack: o_stall_m=0, next edge registers o_rd_wren_w=0, o_bus_err_w=1, -> IDLE; ack in that same cycle wins (normal completion).
REQ-024 While o_stall_m=1, MEM/WB SHALL load a bubble: rd_wren_w=0, flags 0.
REQ-025 Store be by funct3[1:0]: 00 -> 0001<<addr[1:0]; 01 -> 0011<<{addr[1],0}; other -> 1111; wdata byte replicated x4, half x2, word as-is.
REQ-026 Load formatting: 000 LB sign-ext, 001 LH sign-ext, 100 LBU, 101 LHU zero-ext, all others LW; lane chosen by addr[1:0].
REQ-027 o_wb_data_w registers per wb_sel: ALU result, formatted load, or pc+4.
REQ-028 Non-access instructions and completions register i_rd_wren_m, i_rd_m, data; flags 0; latency 1 cycle.
REQ-029 Flags pulse one cycle, cleared by any subsequent register load.

Reset
REQ-030 i_rst=1 at edge: state IDLE, counter 0, all MEM/WB outputs 0; reset SHALL abort a BUSY access.
REQ-031 During reset o_dmem_req=0 and o_stall_m=0.

Verification
REQ-032 LW addr 0x104, rdata 0xDEADBEEF, ack same cycle -> no stall; next cycle o_wb_data_w=0xDEADBEEF, o_rd_wren_w=1.
REQ-033 LB addr 0x103, rdata 0x80FF_0000 -> o_wb_data_w=0xFFFFFF80; LBU -> 0x00000080.
REQ-034 SH addr 0x102, st_data 0x1234ABCD -> be=1100, wdata=0xABCDABCD, we=1.
REQ-035 LW, ack after 3 wait cycles -> o_stall_m high 3 cycles, 3 bubbles, then single write.
REQ-036 No ack 16 cycles -> stall ends, o_bus_err_w=1, o_rd_wren_w=0, FSM IDLE.
REQ-037 LW addr 0x102 -> o_dmem_req=0, o_misalign_w=1; reset while BUSY -> IDLE, outputs 0.

Source files
------------

// File: rtl/memory_stage.sv
// Pipeline memory stage: data-bus request/wait FSM, store lane steering,
// load formatting and the MEM/WB register.
module memory_stage (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_rd_wren_m,
  input  logic        i_mem_wren_m,
  input  logic [1:0]  i_wb_sel_m,
  input  logic [2:0]  i_funct3_m,
  input  logic [4:0]  i_rd_m,
  input  logic [31:0] i_pc_four_m,
  input  logic [31:0] i_st_data_m,
  input  logic [31:0] i_alu_data_m,
  output logic        o_dmem_req,
  output logic        o_dmem_we,
  output logic [31:0] o_dmem_addr,
  output logic [31:0] o_dmem_wdata,
  output logic [3:0]  o_dmem_be,
  input  logic        i_dmem_ack,
  input  logic [31:0] i_dmem_rdata,
  output logic        o_stall_m,
  output logic        o_rd_wren_w,
  output logic [4:0]  o_rd_w,
  output logic [31:0] o_wb_data_w,
  output logic        o_misalign_w,
  output logic        o_bus_err_w
);

  // state | meaning
  // IDLE  | no access outstanding; aligned accesses issue immediately
  // BUSY  | access issued, waiting for ack; counter tracks wait cycles
  typedef enum logic {IDLE, BUSY} state_e;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        access, misalign, timeout, req, stall;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ld_data, wb_data;

  logic        rd_wren_q, rd_wren_d;
  logic [4:0]  rd_q, rd_d;
  logic [31:0] data_q, data_d;
  logic        mis_q, mis_d;
  logic        berr_q, berr_d;

  always_comb begin
    access   = i_mem_wren_m | (i_wb_sel_m == 2'b01);
    misalign = 1'b0;
    case (i_funct3_m[1:0])
      2'b01:   misalign = i_alu_data_m[0];
      2'b10:   misalign = (i_alu_data_m[1:0] != 2'b00);
      default: misalign = 1'b0;
    endcase
    timeout = (state_q == BUSY) && (cnt_q == 4'hF) && !i_dmem_ack;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    req     = 1'b0;
    stall   = 1'b0;
    case (state_q)
      IDLE: begin
        if (access && !misalign) begin
          req = 1'b1;
          if (!i_dmem_ack) begin
            stall   = 1'b1;
            state_d = BUSY;
            cnt_d   = 4'd1;
          end
        end
      end
      BUSY: begin
        req = 1'b1;
        // ack on the last wait cycle still completes normally
        if (i_dmem_ack || cnt_q == 4'hF) begin
          state_d = IDLE;
          cnt_d   = 4'd0;
        end else begin
          stall = 1'b1;
          cnt_d = cnt_q + 4'd1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = 4'd0;
      end
    endcase
    if (i_rst) begin
      req   = 1'b0;
      stall = 1'b0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign o_dmem_req  = req;
  assign o_dmem_we   = req & i_mem_wren_m;
  assign o_dmem_addr = {i_alu_data_m[31:2], 2'b00};
  assign o_stall_m   = stall;

  always_comb begin
    case (i_funct3_m[1:0])
      2'b00: begin
        o_dmem_be    = 4'b0001 << i_alu_data_m[1:0];
        o_dmem_wdata = {4{i_st_data_m[7:0]}};
      end
      2'b01: begin
        o_dmem_be    = 4'b0011 << {i_alu_data_m[1], 1'b0};
        o_dmem_wdata = {2{i_st_data_m[15:0]}};
      end
      default: begin
        o_dmem_be    = 4'b1111;
        o_dmem_wdata = i_st_data_m;
      end
    endcase
  end

  always_comb begin
    case (i_alu_data_m[1:0])
      2'b00:   ld_byte = i_dmem_rdata[7:0];
      2'b01:   ld_byte = i_dmem_rdata[15:8];
      2'b10:   ld_byte = i_dmem_rdata[23:16];
      default: ld_byte = i_dmem_rdata[31:24];
    endcase
    ld_half = i_alu_data_m[1] ? i_dmem_rdata[31:16] : i_dmem_rdata[15:0];
    case (i_funct3_m)
      3'b000:  ld_data = {{24{ld_byte[7]}}, ld_byte};
      3'b001:  ld_data = {{16{ld_half[15]}}, ld_half};
      3'b100:  ld_data = {24'd0, ld_byte};
      3'b101:  ld_data = {16'd0, ld_half};
      default: ld_data = i_dmem_rdata;
    endcase
    case (i_wb_sel_m)
      2'b01:   wb_data = ld_data;
      2'b10:   wb_data = i_pc_four_m;
      default: wb_data = i_alu_data_m;
    endcase
  end

  always_comb begin
    rd_wren_d = i_rd_wren_m;
    rd_d      = i_rd_m;
    data_d    = wb_data;
    mis_d     = 1'b0;
    berr_d    = 1'b0;
    if (stall) begin
      rd_wren_d = 1'b0;
      rd_d      = 5'd0;
      data_d    = 32'd0;
    end else if (state_q == IDLE && access && misalign) begin
      rd_wren_d = 1'b0;
      mis_d     = 1'b1;
    end else if (timeout) begin
      rd_wren_d = 1'b0;
      berr_d    = 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      rd_wren_q <= 1'b0;
      rd_q      <= 5'd0;
      data_q    <= 32'd0;
      mis_q     <= 1'b0;
      berr_q    <= 1'b0;
    end else begin
      rd_wren_q <= rd_wren_d;
      rd_q      <= rd_d;
      data_q    <= data_d;
      mis_q     <= mis_d;
      berr_q    <= berr_d;
    end
  end

  assign o_rd_wren_w  = rd_wren_q;
  assign o_rd_w       = rd_q;
  assign o_wb_data_w  = data_q;
  assign o_misalign_w = mis_q;
  assign o_bus_err_w  = berr_q;

endmodule

// File: tb/tb_memory_stage.sv
// Directed bench for memory_stage: expected MEM/WB contents are queued as
// each instruction is driven and compared after the clock edge.
module tb_memory_stage;

  logic        clk;
  logic        rst;
  logic        rd_wren_m, mem_wren_m;
  logic [1:0]  wb_sel_m;
  logic [2:0]  funct3_m;
  logic [4:0]  rd_m;
  logic [31:0] pc_four_m, st_data_m, alu_data_m;
  logic        dmem_req, dmem_we;
  logic [31:0] dmem_addr, dmem_wdata;
  logic [3:0]  dmem_be;
  logic        dmem_ack;
  logic [31:0] dmem_rdata;
  logic        stall_m;
  logic        rd_wren_w;
  logic [4:0]  rd_w;
  logic [31:0] wb_data_w;
  logic        misalign_w, bus_err_w;

  int checks   = 0;
  int failures = 0;

  typedef struct packed {
    logic        rd_wren;
    logic [4:0]  rd;
    logic [31:0] data;
    logic        mis;
    logic        berr;
    logic        full;
  } exp_t;

  exp_t sb[$];

  memory_stage dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_rd_wren_m  (rd_wren_m),
    .i_mem_wren_m (mem_wren_m),
    .i_wb_sel_m   (wb_sel_m),
    .i_funct3_m   (funct3_m),
    .i_rd_m       (rd_m),
    .i_pc_four_m  (pc_four_m),
    .i_st_data_m  (st_data_m),
    .i_alu_data_m (alu_data_m),
    .o_dmem_req   (dmem_req),
    .o_dmem_we    (dmem_we),
    .o_dmem_addr  (dmem_addr),
    .o_dmem_wdata (dmem_wdata),
    .o_dmem_be    (dmem_be),
    .i_dmem_ack   (dmem_ack),
    .i_dmem_rdata (dmem_rdata),
    .o_stall_m    (stall_m),
    .o_rd_wren_w  (rd_wren_w),
    .o_rd_w       (rd_w),
    .o_wb_data_w  (wb_data_w),
    .o_misalign_w (misalign_w),
    .o_bus_err_w  (bus_err_w)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic exp_t ex(input logic w, input logic [4:0] r, input logic [31:0] d);
    return '{rd_wren: w, rd: r, data: d, mis: 1'b0, berr: 1'b0, full: 1'b1};
  endfunction

  function automatic exp_t bub();
    return '{rd_wren: 1'b0, rd: 5'd0, data: 32'd0, mis: 1'b0, berr: 1'b0, full: 1'b0};
  endfunction

  function automatic exp_t flag(input logic m, input logic b);
    return '{rd_wren: 1'b0, rd: 5'd0, data: 32'd0, mis: m, berr: b, full: 1'b0};
  endfunction

  task automatic set_in(input logic w, input logic s, input logic [1:0] sel,
                        input logic [2:0] f3, input logic [4:0] r,
                        input logic [31:0] alu, input logic [31:0] st,
                        input logic [31:0] pc4);
    rd_wren_m  = w;
    mem_wren_m = s;
    wb_sel_m   = sel;
    funct3_m   = f3;
    rd_m       = r;
    alu_data_m = alu;
    st_data_m  = st;
    pc_four_m  = pc4;
    #1;
  endtask

  task automatic bus(input logic ack, input logic req_e, input logic stall_e);
    chk("dmem_req", dmem_req, req_e);
    chk("stall_m", stall_m, stall_e);
  endtask

  task automatic step(input exp_t e);
    exp_t got;
    sb.push_back(e);
    @(posedge clk);
    #1;
    got = sb.pop_front();
    chk("rd_wren_w", rd_wren_w, got.rd_wren);
    chk("misalign_w", misalign_w, got.mis);
    chk("bus_err_w", bus_err_w, got.berr);
    if (got.full) begin
      chk("rd_w", rd_w, got.rd);
      chk("wb_data_w", wb_data_w, got.data);
    end
  endtask

  initial begin
    rst = 1'b1;
    dmem_ack = 1'b0;
    dmem_rdata = 32'd0;
    set_in(1, 0, 2'b01, 3'b010, 5'd3, 32'h104, 0, 0);
    #1;
    bus(0, 0, 0);
    step(ex(0, 0, 0));
    rst = 1'b0;

    set_in(1, 0, 2'b00, 3'b010, 5'd5, 32'h1111_1111, 0, 32'h400);
    bus(0, 0, 0);
    step(ex(1, 5, 32'h1111_1111));
    set_in(1, 0, 2'b11, 3'b010, 5'd9, 32'h2222_2222, 0, 32'h400);
    step(ex(1, 9, 32'h2222_2222));
    set_in(1, 0, 2'b10, 3'b000, 5'd6, 32'h33, 0, 32'h200);
    step(ex(1, 6, 32'h200));

    dmem_ack = 1'b1;
    dmem_rdata = 32'hDEAD_BEEF;
    set_in(1, 0, 2'b01, 3'b010, 5'd7, 32'h104, 0, 0);
    bus(1, 1, 0);
    chk("dmem_we_load", dmem_we, 1'b0);
    chk("dmem_addr_lw", dmem_addr, 32'h104);
    step(ex(1, 7, 32'hDEAD_BEEF));

    dmem_rdata = 32'h80FF_0000;
    set_in(1, 0, 2'b01, 3'b000, 5'd7, 32'h103, 0, 0);
    chk("dmem_addr_lb", dmem_addr, 32'h100);
    step(ex(1, 7, 32'hFFFF_FF80));
    set_in(1, 0, 2'b01, 3'b100, 5'd7, 32'h103, 0, 0);
    step(ex(1, 7, 32'h0000_0080));
    set_in(1, 0, 2'b01, 3'b001, 5'd7, 32'h102, 0, 0);
    step(ex(1, 7, 32'hFFFF_80FF));
    set_in(1, 0, 2'b01, 3'b101, 5'd7, 32'h102, 0, 0);
    step(ex(1, 7, 32'h0000_80FF));

    set_in(0, 1, 2'b00, 3'b001, 5'd8, 32'h102, 32'h1234_ABCD, 0);
    bus(1, 1, 0);
    chk("sh_we", dmem_we, 1'b1);
    chk("sh_be", dmem_be, 4'b1100);
    chk("sh_wdata", dmem_wdata, 32'hABCD_ABCD);
    step(ex(0, 8, 32'h102));
    set_in(0, 1, 2'b00, 3'b000, 5'd8, 32'h101, 32'h0000_00A5, 0);
    chk("sb_be", dmem_be, 4'b0010);
    chk("sb_wdata", dmem_wdata, 32'hA5A5_A5A5);
    step(ex(0, 8, 32'h101));
    set_in(0, 1, 2'b00, 3'b010, 5'd8, 32'h108, 32'h0102_0304, 0);
    chk("sw_be", dmem_be, 4'b1111);
    chk("sw_wdata", dmem_wdata, 32'h0102_0304);
    step(ex(0, 8, 32'h108));

    dmem_ack = 1'b0;
    dmem_rdata = 32'd0;
    set_in(1, 0, 2'b01, 3'b010, 5'd10, 32'h108, 0, 0);
    for (int i = 0; i < 3; i++) begin
      bus(0, 1, 1);
      step(bub());
    end
    dmem_ack = 1'b1;
    dmem_rdata = 32'hCAFE_F00D;
    #1;
    bus(1, 1, 0);
    step(ex(1, 10, 32'hCAFE_F00D));
    dmem_ack = 1'b0;
    set_in(0, 0, 2'b00, 3'b000, 5'd11, 32'h44, 0, 0);
    bus(0, 0, 0);
    step(ex(0, 11, 32'h44));

    set_in(1, 0, 2'b01, 3'b010, 5'd12, 32'h10C, 0, 0);
    for (int i = 0; i < 15; i++) begin
      bus(0, 1, 1);
      step(bub());
    end
    bus(0, 1, 0);
    step(flag(0, 1));
    set_in(1, 0, 2'b00, 3'b000, 5'd13, 32'h55, 0, 0);
    bus(0, 0, 0);
    step(ex(1, 13, 32'h55));

    set_in(1, 0, 2'b01, 3'b010, 5'd14, 32'h110, 0, 0);
    for (int i = 0; i < 15; i++) step(bub());
    dmem_ack = 1'b1;
    dmem_rdata = 32'h0BAD_F00D;
    #1;
    bus(1, 1, 0);
    step(ex(1, 14, 32'h0BAD_F00D));
    dmem_ack = 1'b0;

    set_in(1, 0, 2'b01, 3'b010, 5'd15, 32'h102, 0, 0);
    bus(0, 0, 0);
    step(flag(1, 0));
    set_in(1, 0, 2'b01, 3'b001, 5'd15, 32'h101, 0, 0);
    bus(0, 0, 0);
    step(flag(1, 0));
    set_in(0, 1, 2'b00, 3'b010, 5'd15, 32'h102, 32'hFFFF_FFFF, 0);
    bus(0, 0, 0);
    chk("mis_we", dmem_we, 1'b0);
    step(flag(1, 0));
    set_in(1, 0, 2'b00, 3'b000, 5'd16, 32'h66, 0, 0);
    step(ex(1, 16, 32'h66));

    set_in(1, 0, 2'b01, 3'b010, 5'd17, 32'h114, 0, 0);
    step(bub());
    step(bub());
    rst = 1'b1;
    #1;
    bus(0, 0, 0);
    step(ex(0, 0, 0));
    rst = 1'b0;
    set_in(1, 0, 2'b00, 3'b000, 5'd18, 32'h77, 0, 0);
    bus(0, 0, 0);
    step(ex(1, 18, 32'h77));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
